fp_to_int_conv: RTL and testbench
=================================

// Module: fp_to_int_conv
// PURPOSE
//  Iterative IEEE-754 single-precision to signed-integer converter that consumes the 32-bit
//  result of the FP adder (wrapper drives in_valid with the settled sum). Truncates toward zero,
//  saturates on overflow. Shifts one bit per cycle, matching the adder's multi-cycle style.
//  Valid/ready handshake on both sides; one conversion in flight at a time.
// PARAMETERS
//  OUT_W  32  integer result width, legal range 24..32 (magnitude register is OUT_W bits)
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      fp_in holds an operand
//  in_ready   out  1      converter can accept (1 only in IDLE, 0 while rst high)
//  fp_in      in   32     IEEE-754 single {sign, exp[7:0], frac[22:0]}
//  out_valid  out  1      int_out/ovf/invalid hold a result
//  out_ready  in   1      consumer takes result
//  int_out    out  OUT_W  two's-complement result
//  ovf        out  1      result saturated (|x| too large or Inf)
//  invalid    out  1      input was NaN
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, int_out=0, ovf=0, invalid=0, shift counter=0. Reset wins over
//   every other event; reset mid-conversion discards the operand, no output is produced.
//  States: IDLE -> LOAD -> SHIFT (0..n cycles) -> SIGN -> HOLD -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready capture s=fp_in[31], e=fp_in[30:23], m={1,fp_in[22:0]}
//   (m=0 if e==0: denormals/zero flush to 0); go LOAD. in_valid outside IDLE ignored, not queued.
//  LOAD (1 cycle), k=e-127, classify in priority order:
//   - e==255, frac!=0 (NaN): mag=0, invalid=1, go SIGN with s forced 0.
//   - e==255, frac==0 (Inf) or k>=OUT_W-1: saturate, ovf=1, go SIGN with sat value
//     (s=0 -> 2^(OUT_W-1)-1, s=1 -> -2^(OUT_W-1)); exception: s=1, k==OUT_W-1, frac==0
//     is exactly -2^(OUT_W-1), ovf=0.
//   - e<127 (|x|<1, incl. zero/denormal): mag=0, go SIGN.
//   - else mag=m zero-extended to OUT_W; n=|k-23|; dir=left if k>23 else right;
//     n==0 -> SIGN, else load counter with n and go SHIFT.
//  SHIFT: one logical shift of mag per cycle (right shifts drop bits = truncation), counter-1;
//   on the shift that brings counter to 0 go SIGN. Max n=23 (k=0); left shifts never lose bits.
//  SIGN (1 cycle): int_out = s ? -mag : mag (saturation value passed through unchanged);
//   ovf/invalid registered; out_valid<=1; go HOLD.
//  HOLD: int_out, ovf, invalid, out_valid stable while out_ready=0. When out_ready=1: out_valid<=0
//   next edge, go IDLE (new operand accepted no earlier than the cycle after).
//  Latency: out_valid rises exactly n+2 edges after the accepting edge (n=0 for special cases);
//   throughput one result per n+4 cycles with out_ready tied high.
//  Flags ovf/invalid meaningful only while out_valid=1; cleared on next acceptance.
// TESTING
//  1. fp_in=0x40490FDB (3.14159), out_ready=1 -> int_out=3, ovf=0, out_valid 24 edges after accept.
//  2. 0xC2F6E979 (-123.456) -> int_out=0xFFFFFF85 (-123); 0x4E800001 -> 0x40000080 (7 left shifts).
//  3. 0x4F000000 -> 0x7FFFFFFF, ovf=1; 0xCF000000 -> 0x80000000, ovf=0;
//     0xFF800000 -> 0x80000000, ovf=1.
//  4. 0x7FC00000 -> 0, invalid=1; 0x3F7FFFFF -> 0; 0x00000001 -> 0; 0x80000000 -> 0; flags 0.
//  5. Backpressure: out_ready=0 for 10 cycles -> outputs stable, in_ready=0, pulsed in_valid
//     ignored; out_ready=1 -> out_valid drops next edge, in_ready=1.
//  6. rst pulsed during SHIFT of 0x40490FDB -> out_valid=0, in_ready=1 the cycle after rst
//     falls; next operand converts normally.

Source files
------------

// File: rtl/fp_to_int_conv.sv
// Iterative IEEE-754 single to signed integer converter.
// Truncates toward zero, saturates on overflow, one shift per cycle.
module fp_to_int_conv #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      fp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] int_out,
  output logic             ovf,
  output logic             invalid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_SIGN  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic signed [9:0] KMAX = 10'(OUT_W - 1);
  localparam logic [OUT_W-1:0] MAXP = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [2:0]       state_q;
  logic             s_q;
  logic [7:0]       e_q;
  logic [22:0]      frac_q;
  logic [OUT_W-1:0] mag_q;
  logic [4:0]       cnt_q;
  logic             left_q;
  logic             sat_q;
  logic             ovf_q;
  logic             inv_q;

  logic signed [9:0] k;
  logic              is_nan;
  logic              big;
  logic              exact_min;
  logic [4:0]        nl;
  logic [4:0]        nr;

  assign in_ready = (state_q == S_IDLE) && !rst;

  // Classify the captured operand from its unbiased exponent.
  always_comb begin
    k         = $signed({2'b00, e_q}) - 10'sd127;
    is_nan    = (e_q == 8'hFF) && (frac_q != '0);
    big       = (e_q == 8'hFF) || (k >= KMAX);
    exact_min = s_q && (k == KMAX) && (frac_q == '0);
    nl        = 5'(k - 10'sd23);
    nr        = 5'(10'sd23 - k);
  end

  // Conversion sequencer: capture, classify, shift, apply sign, hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      s_q       <= 1'b0;
      e_q       <= '0;
      frac_q    <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      int_out   <= '0;
      ovf       <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            s_q     <= fp_in[31];
            e_q     <= fp_in[30:23];
            frac_q  <= fp_in[22:0];
            mag_q   <= (fp_in[30:23] == 8'd0) ? '0
                     : OUT_W'({1'b1, fp_in[22:0]});
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
            ovf     <= 1'b0;
            invalid <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (is_nan) begin
            mag_q   <= '0;
            inv_q   <= 1'b1;
            s_q     <= 1'b0;
            state_q <= S_SIGN;
          end else if (big) begin
            sat_q   <= 1'b1;
            ovf_q   <= !exact_min;
            mag_q   <= s_q ? MINN : MAXP;
            state_q <= S_SIGN;
          end else if (k < 10'sd0) begin
            mag_q   <= '0;
            state_q <= S_SIGN;
          end else if (k > 10'sd23) begin
            left_q  <= 1'b1;
            cnt_q   <= nl;
            state_q <= S_SHIFT;
          end else if (k == 10'sd23) begin
            state_q <= S_SIGN;
          end else begin
            left_q  <= 1'b0;
            cnt_q   <= nr;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= S_SIGN;
        end
        S_SIGN: begin
          int_out   <= sat_q ? mag_q : (s_q ? -mag_q : mag_q);
          ovf       <= ovf_q;
          invalid   <= inv_q;
          out_valid <= 1'b1;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int_conv.sv
// Directed bench for fp_to_int_conv with a result scoreboard.
// Checks value, flags, latency, backpressure and reset abort.
module tb_fp_to_int_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        ovf;
  logic        invalid;

  typedef struct {
    logic [31:0] val;
    logic        ovf;
    logic        inv;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   passes = 0;
  int   total  = 0;

  fp_to_int_conv #(.OUT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .fp_in(fp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .int_out(int_out), .ovf(ovf), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [31:0] fp, input logic [31:0] ev,
                      input logic eo, input logic ei, input int el);
    exp_t x;
    int   w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    x.val = ev; x.ovf = eo; x.inv = ei; x.lat = el;
    sb.push_back(x);
    fp_in    = fp;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t x;
    int   lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    x = sb.pop_front();
    chk({tag, "_lat"}, lat, x.lat);
    chk({tag, "_val"}, int_out, x.val);
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, x.ovf});
    chk({tag, "_inv"}, {31'd0, invalid}, {31'd0, x.inv});
  endtask

  task automatic drain(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic conv(input string tag, input logic [31:0] fp,
                      input logic [31:0] ev, input logic eo,
                      input logic ei, input int el);
    send(fp, ev, eo, ei, el);
    collect(tag);
    drain(tag);
  endtask

  initial begin
    logic [31:0] hv;
    logic        ho, hi;
    rst       = 1'b1;
    in_valid  = 1'b0;
    fp_in     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_int_out", int_out, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_invalid", {31'd0, invalid}, 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    conv("pi",      32'h40490FDB, 32'h00000003, 0, 0, 24);
    conv("neg123",  32'hC2F6E979, 32'hFFFFFF85, 0, 0, 19);
    conv("left7",   32'h4E800001, 32'h40000080, 0, 0, 9);
    conv("pos_sat", 32'h4F000000, 32'h7FFFFFFF, 1, 0, 2);
    conv("neg_min", 32'hCF000000, 32'h80000000, 0, 0, 2);
    conv("neg_inf", 32'hFF800000, 32'h80000000, 1, 0, 2);
    conv("nan",     32'h7FC00000, 32'h00000000, 0, 1, 2);
    conv("below1",  32'h3F7FFFFF, 32'h00000000, 0, 0, 2);
    conv("denorm",  32'h00000001, 32'h00000000, 0, 0, 2);
    conv("negzero", 32'h80000000, 32'h00000000, 0, 0, 2);
    conv("one",     32'h3F800000, 32'h00000001, 0, 0, 25);
    conv("k23",     32'h4B000000, 32'h00800000, 0, 0, 2);
    conv("maxpos",  32'h4EFFFFFF, 32'h7FFFFF80, 0, 0, 9);
    conv("maxneg",  32'hCEFFFFFF, 32'h80000080, 0, 0, 9);
    conv("pos_inf", 32'h7F800000, 32'h7FFFFFFF, 1, 0, 2);
    conv("neg_big", 32'hCF000001, 32'h80000000, 1, 0, 2);

    out_ready = 1'b0;
    send(32'hC2F6E979, 32'hFFFFFF85, 0, 0, 19);
    collect("bp");
    hv = int_out; ho = ovf; hi = invalid;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      fp_in    = 32'h3F800000;
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_val", int_out, hv);
      chk("bp_hold_flags", {30'd0, ovf, invalid}, {30'd0, ho, hi});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("bp");
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 chk("bp_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    send(32'h40490FDB, 32'h0, 0, 0, 0);
    void'(sb.pop_front());
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 chk("rst_no_out", {31'd0, out_valid}, 32'd0);
    end
    conv("after_rst", 32'h40490FDB, 32'h00000003, 0, 0, 24);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
